// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by alu_seq and its multiplier.
//   - opcode encodings OP_ADD..OP_MUL (4-bit opcode field)
//   - state_t: alu_seq control states
//   - flag bit positions inside flags_t
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_CMP  = 4'd6;
    localparam logic [3:0] OP_NOP  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL_BUSY,
        S_HOLD
    } state_t;

    localparam int unsigned FLAG_CARRY  = 0;
    localparam int unsigned FLAG_BORROW = 1;
    localparam int unsigned FLAG_EQUAL  = 2;
    localparam int unsigned FLAG_LESS   = 3;
    localparam int unsigned FLAG_MORE   = 4;
    localparam int unsigned FLAG_ERR    = 5;
    localparam int unsigned NUM_FLAGS   = 6;

    typedef logic [NUM_FLAGS-1:0] flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, one iteration per clock.
//   clk, rst      clock, asynchronous active-high reset
//   start         load a/b and begin (ignored while busy)
//   a, b          WIDTH-bit operands, sampled on start
//   busy          iterations in progress
//   done          high during the final iteration
//   product       2*WIDTH result of the current iteration; the full
//                 product when done is high, so the caller can register
//                 it on the same edge the last iteration completes
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;   // holds the unused multiplier bits, then product low half
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum;
    logic [2*WIDTH-1:0] step;

    // Right-shifting accumulator: add the multiplicand into the high half
    // when the current multiplier LSB is set, then shift the pair right.
    always_comb begin
        sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        step = {sum, acc_lo[WIDTH-1:1]};
    end

    assign done    = busy && (cnt == CW'(WIDTH - 1));
    assign product = step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else if (start && !busy) begin
            busy   <= 1'b1;
            cnt    <= '0;
            mcand  <= a;
            acc_hi <= '0;
            acc_lo <= b;
        end else if (busy) begin
            {acc_hi, acc_lo} <= step;
            cnt              <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes and a multi-cycle MUL.
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   operand beat handshake (A, B, opcode)
//   A, B, opcode         operands and 4-bit operation select
//   out_valid, out_ready result beat handshake
//   C, C_hi              result; C_hi is the MUL high half, 0 otherwise
//   carry, borrow, equal, less, more, err   flags, all rewritten every beat
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          SIGNED_CMP = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] C_hi,
    output logic             carry,
    output logic             borrow,
    output logic             equal,
    output logic             less,
    output logic             more,
    output logic             err
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_t state, state_nx;

    logic               accept;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0]   res_c;
    flags_t             res_flags;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     shr_ext;
    logic [SHW-1:0]     sh;
    logic               lt;

    logic [WIDTH-1:0]   c_r;
    logic [WIDTH-1:0]   chi_r;
    flags_t             flags_r;

    // ---------------- single-cycle datapath ----------------
    always_comb begin
        res_c     = '0;
        res_flags = '0;
        sum       = '0;
        diff      = '0;
        shl_ext   = '0;
        shr_ext   = '0;
        lt        = 1'b0;
        sh        = B[SHW-1:0];
        case (opcode)
            OP_ADD: begin
                sum                   = {1'b0, A} + {1'b0, B};
                res_c                 = sum[WIDTH-1:0];
                res_flags[FLAG_CARRY] = sum[WIDTH];
            end
            OP_SUB: begin
                diff                   = {1'b0, A} - {1'b0, B};
                res_c                  = diff[WIDTH-1:0];
                res_flags[FLAG_BORROW] = diff[WIDTH];
            end
            OP_XOR:  res_c = A ^ B;
            OP_AND:  res_c = A & B;
            OP_NOR:  res_c = ~(A | B);
            OP_NAND: res_c = ~(A & B);
            OP_CMP: begin
                if (SIGNED_CMP) begin
                    lt = $signed(A) < $signed(B);
                end else begin
                    lt = A < B;
                end
                res_flags[FLAG_EQUAL] = (A == B);
                res_flags[FLAG_LESS]  = lt;
                res_flags[FLAG_MORE]  = !lt && (A != B);
            end
            // One spare bit on the outgoing side catches the last bit
            // shifted out; it stays 0 when sh is 0.
            OP_SHL: begin
                shl_ext               = {1'b0, A} << sh;
                res_c                 = shl_ext[WIDTH-1:0];
                res_flags[FLAG_CARRY] = shl_ext[WIDTH];
            end
            OP_SHR: begin
                shr_ext               = {A, 1'b0} >> sh;
                res_c                 = shr_ext[WIDTH:1];
                res_flags[FLAG_CARRY] = shr_ext[0];
            end
            OP_NOP, OP_MUL: begin
            end
            default: res_flags[FLAG_ERR] = 1'b1;
        endcase
    end

    // ---------------- multiplier ----------------
    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // HOLD forwards out_ready to in_ready, so a new beat can be taken on
    // the same edge the current result is consumed.
    always_comb begin
        state_nx  = state;
        mul_start = 1'b0;
        in_ready  = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE, S_HOLD: begin
                in_ready = !mul_busy && ((state == S_IDLE) || out_ready);
                accept   = in_valid && in_ready;
                if (accept) begin
                    if (opcode == OP_MUL) begin
                        mul_start = 1'b1;
                        state_nx  = S_MUL_BUSY;
                    end else begin
                        state_nx  = S_HOLD;
                    end
                end else if (state == S_HOLD && out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            S_MUL_BUSY: begin
                if (mul_done) begin
                    state_nx = S_HOLD;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_r     <= '0;
            chi_r   <= '0;
            flags_r <= '0;
        end else if (accept && opcode != OP_MUL) begin
            c_r     <= res_c;
            chi_r   <= '0;
            flags_r <= res_flags;
        end else if (mul_done) begin
            {chi_r, c_r} <= mul_product;
            flags_r      <= '0;
        end
    end

    assign out_valid = (state == S_HOLD);
    assign C         = c_r;
    assign C_hi      = chi_r;
    assign carry     = flags_r[FLAG_CARRY];
    assign borrow    = flags_r[FLAG_BORROW];
    assign equal     = flags_r[FLAG_EQUAL];
    assign less      = flags_r[FLAG_LESS];
    assign more      = flags_r[FLAG_MORE];
    assign err       = flags_r[FLAG_ERR];

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq against an arithmetic
// reference model. Three instances: 8-bit unsigned CMP, 8-bit signed CMP
// (sharing the same inputs), and a 16-bit instance for the wide MUL.
module tb_alu_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // shared 8-bit stimulus
    logic       iv, ordy;
    logic [7:0] a, b;
    logic [3:0] op;

    logic       ir0, ov0, cy0, bw0, eq0, lt0, gt0, er0;
    logic [7:0] c0, chi0;
    logic       ir1, ov1, cy1, bw1, eq1, lt1, gt1, er1;
    logic [7:0] c1, chi1;
    logic [5:0] f0, f1;
    assign f0 = {cy0, bw0, eq0, lt0, gt0, er0};
    assign f1 = {cy1, bw1, eq1, lt1, gt1, er1};

    // 16-bit instance
    logic        iv2, or2;
    logic [15:0] a2, b2;
    logic [3:0]  op2;
    logic        ir2, ov2, cy2, bw2, eq2, lt2, gt2, er2;
    logic [15:0] c2, chi2;
    logic [5:0]  f2;
    assign f2 = {cy2, bw2, eq2, lt2, gt2, er2};

    alu_seq #(.WIDTH(8), .SIGNED_CMP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir0), .A(a), .B(b), .opcode(op),
        .out_valid(ov0), .out_ready(ordy), .C(c0), .C_hi(chi0),
        .carry(cy0), .borrow(bw0), .equal(eq0), .less(lt0), .more(gt0), .err(er0)
    );

    alu_seq #(.WIDTH(8), .SIGNED_CMP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir1), .A(a), .B(b), .opcode(op),
        .out_valid(ov1), .out_ready(ordy), .C(c1), .C_hi(chi1),
        .carry(cy1), .borrow(bw1), .equal(eq1), .less(lt1), .more(gt1), .err(er1)
    );

    alu_seq #(.WIDTH(16), .SIGNED_CMP(1'b0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2), .opcode(op2),
        .out_valid(ov2), .out_ready(or2), .C(c2), .C_hi(chi2),
        .carry(cy2), .borrow(bw2), .equal(eq2), .less(lt2), .more(gt2), .err(er2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model for the 8-bit instances.
    // Returns {C_hi[7:0], C[7:0], carry, borrow, equal, less, more, err}.
    function automatic logic [21:0] model(input int opi, input int ai, input int bi, input bit sgn);
        int c, chi, s, sa, sb, sh;
        bit cy, bw, eq, lt, gt, er;
        logic [7:0] c8, chi8;
        c = 0; chi = 0; cy = 0; bw = 0; eq = 0; lt = 0; gt = 0; er = 0;
        sh = bi % 8;
        case (opi)
            0: begin s = ai + bi; c = s % 256; cy = (s > 255); end
            1: begin c = (ai - bi + 256) % 256; bw = (ai < bi); end
            2: c = ai ^ bi;
            3: c = ai & bi;
            4: c = 255 - (ai | bi);
            5: c = 255 - (ai & bi);
            6: begin
                sa = ai; sb = bi;
                if (sgn) begin
                    if (sa > 127) sa -= 256;
                    if (sb > 127) sb -= 256;
                end
                eq = (sa == sb); lt = (sa < sb); gt = (sa > sb);
            end
            7: ;
            8: begin
                s = ai * (1 << sh);
                c = s % 256;
                cy = (sh != 0) && ((s / 256) % 2 == 1);
            end
            9: begin
                c = ai / (1 << sh);
                cy = (sh != 0) && (((ai / (1 << (sh - 1))) % 2) == 1);
            end
            10: begin s = ai * bi; c = s % 256; chi = s / 256; end
            default: er = 1;
        endcase
        c8 = 8'(c);
        chi8 = 8'(chi);
        return {chi8, c8, cy, bw, eq, lt, gt, er};
    endfunction

    // One single-cycle beat on the 8-bit pair; result due right after the accepting edge.
    task automatic single(input int opi, input int ai, input int bi, input string tag);
        logic [21:0] e0, e1;
        e0 = model(opi, ai, bi, 1'b0);
        e1 = model(opi, ai, bi, 1'b1);
        @(negedge clk);
        chk({tag, " in_ready"}, 32'(ir0), 32'd1);
        iv = 1'b1; op = opi[3:0]; a = ai[7:0]; b = bi[7:0];
        @(negedge clk);
        iv = 1'b0; a = 8'($urandom); b = 8'($urandom); op = 4'($urandom);
        chk({tag, " out_valid"}, 32'(ov0), 32'd1);
        chk({tag, " C"}, 32'(c0), 32'(e0[13:6]));
        chk({tag, " C_hi"}, 32'(chi0), 32'(e0[21:14]));
        chk({tag, " flags"}, 32'(f0), 32'(e0[5:0]));
        chk({tag, " C signed-inst"}, 32'(c1), 32'(e1[13:6]));
        chk({tag, " flags signed-inst"}, 32'(f1), 32'(e1[5:0]));
    endtask

    // MUL on the 8-bit instance; measures edges from acceptance to out_valid.
    task automatic mul8(input int ai, input int bi, input string tag);
        logic [21:0] e;
        int n;
        e = model(10, ai, bi, 1'b0);
        @(negedge clk);
        iv = 1'b1; op = 4'd10; a = ai[7:0]; b = bi[7:0];
        @(negedge clk);
        iv = 1'b0; a = 8'($urandom); b = 8'($urandom);
        n = 0;
        while (ov0 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'd8);
        chk({tag, " C"}, 32'(c0), 32'(e[13:6]));
        chk({tag, " C_hi"}, 32'(chi0), 32'(e[21:14]));
        chk({tag, " flags"}, 32'(f0), 32'd0);
    endtask

    task automatic mul16(input int ai, input int bi, input string tag);
        longint p;
        int n;
        logic [31:0] pv;
        p = longint'(ai) * longint'(bi);
        pv = 32'(p);
        @(negedge clk);
        iv2 = 1'b1; op2 = 4'd10; a2 = ai[15:0]; b2 = bi[15:0];
        @(negedge clk);
        iv2 = 1'b0; a2 = 16'($urandom); b2 = 16'($urandom);
        n = 0;
        while (ov2 !== 1'b1 && n < 60) begin
            chk({tag, " in_ready busy"}, 32'(ir2), 32'd0);
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'd16);
        chk({tag, " C"}, 32'(c2), 32'(pv[15:0]));
        chk({tag, " C_hi"}, 32'(chi2), 32'(pv[31:16]));
        chk({tag, " flags"}, 32'(f2), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ra, rb, ro;
        rst = 1'b1; iv = 1'b0; ordy = 1'b1; a = '0; b = '0; op = '0;
        iv2 = 1'b0; or2 = 1'b1; a2 = '0; b2 = '0; op2 = '0;
        #1;
        chk("reset in_ready", 32'(ir0), 32'd1);
        chk("reset out_valid", 32'(ov0), 32'd0);
        chk("reset C", 32'(c0), 32'd0);
        chk("reset C_hi", 32'(chi0), 32'd0);
        chk("reset flags", 32'(f0), 32'd0);
        chk("reset out_valid w16", 32'(ov2), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // directed single-cycle cases
        single(0, 8'hD3, 8'hEC, "ADD carry");
        chk("ADD carry const C", 32'(c0), 32'hBF);
        chk("ADD carry const flags", 32'(f0), 32'b100000);
        single(1, 8'h02, 8'h3C, "SUB borrow");
        chk("SUB borrow const C", 32'(c0), 32'hC6);
        single(1, 8'h12, 8'h0C, "SUB no borrow");
        chk("SUB no borrow const C", 32'(c0), 32'h06);
        single(6, 8'h80, 8'h01, "CMP 80/01");
        chk("CMP unsigned more", 32'(f0), 32'b000010);
        chk("CMP signed less", 32'(f1), 32'b000100);
        single(6, 8'hAA, 8'hAA, "CMP equal");
        chk("CMP equal both", 32'({f0, f1}), 32'b001000_001000);
        single(7, 8'h55, 8'h33, "NOP");
        single(8, 8'h81, 8'h00, "SHL by 0");
        single(8, 8'h81, 8'h07, "SHL by 7");
        single(9, 8'h81, 8'h01, "SHR by 1");
        single(9, 8'h80, 8'h07, "SHR by 7");
        single(15, 8'h12, 8'h34, "illegal 15");

        // random single-cycle beats
        repeat (40) begin
            ro = $urandom_range(0, 15);
            if (ro == 10) ro = 7;
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            single(ro, ra, rb, "random");
        end

        // MUL 0xFF*0xFF with backpressure
        @(negedge clk);
        ordy = 1'b0;
        iv = 1'b1; op = 4'd10; a = 8'hFF; b = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            iv = 1'b0; a = 8'($urandom); b = 8'($urandom); op = 4'($urandom);
            chk("MUL busy in_ready", 32'(ir0), 32'd0);
            chk("MUL busy out_valid", 32'(ov0), 32'd0);
        end
        @(negedge clk);
        chk("MUL out_valid", 32'(ov0), 32'd1);
        chk("MUL C", 32'(c0), 32'h01);
        chk("MUL C_hi", 32'(chi0), 32'hFE);
        chk("MUL flags", 32'(f0), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 8'($urandom); b = 8'($urandom);
            chk("HOLD out_valid", 32'(ov0), 32'd1);
            chk("HOLD in_ready", 32'(ir0), 32'd0);
            chk("HOLD C", 32'(c0), 32'h01);
            chk("HOLD C_hi", 32'(chi0), 32'hFE);
        end
        ordy = 1'b1;
        @(negedge clk);
        chk("HOLD released", 32'(ov0), 32'd0);

        repeat (4) mul8($urandom_range(0, 255), $urandom_range(0, 255), "MUL random");
        single(3, 8'hF0, 8'h3C, "AND after MUL");

        // back-to-back stream with out_ready high
        @(negedge clk);
        iv = 1'b1; op = 4'd2; a = 8'hF0; b = 8'hAA;
        @(negedge clk);
        chk("b2b XOR valid", 32'(ov0), 32'd1);
        chk("b2b XOR C", 32'(c0), 32'h5A);
        chk("b2b in_ready", 32'(ir0), 32'd1);
        op = 4'd5;
        @(negedge clk);
        chk("b2b NAND C", 32'(c0), 32'h5F);
        chk("b2b NAND flags", 32'(f0), 32'd0);
        op = 4'd13;
        @(negedge clk);
        chk("b2b illegal C", 32'(c0), 32'h00);
        chk("b2b illegal flags", 32'(f0), 32'b000001);
        op = 4'd8; a = 8'h81; b = 8'h01;
        @(negedge clk);
        iv = 1'b0;
        chk("b2b SHL valid", 32'(ov0), 32'd1);
        chk("b2b SHL C", 32'(c0), 32'h02);
        chk("b2b SHL flags", 32'(f0), 32'b100000);
        @(negedge clk);
        chk("b2b drained", 32'(ov0), 32'd0);

        // 16-bit MUL
        mul16(16'hFFFF, 16'h0003, "MUL16 directed");
        chk("MUL16 const C", 32'(c2), 32'hFFFD);
        chk("MUL16 const C_hi", 32'(chi2), 32'h0002);
        mul16($urandom_range(0, 65535), $urandom_range(0, 65535), "MUL16 random");
        mul16(16'hFFFF, 16'hFFFF, "MUL16 max");

        // reset three cycles into a MUL
        single(0, 8'h7F, 8'h7F, "ADD before abort");
        @(negedge clk);
        iv = 1'b1; op = 4'd10; a = 8'hC3; b = 8'h5A;
        @(negedge clk);
        iv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort out_valid", 32'(ov0), 32'd0);
        chk("abort in_ready", 32'(ir0), 32'd1);
        chk("abort C", 32'(c0), 32'd0);
        chk("abort C_hi", 32'(chi0), 32'd0);
        chk("abort flags", 32'(f0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        single(0, 8'h01, 8'h01, "ADD after abort");
        chk("ADD after abort const C", 32'(c0), 32'h02);
        repeat (12) begin
            @(negedge clk);
            chk("no residue out_valid", 32'(ov0), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
